// File: rtl/bulls_cows_pkg.sv
// rtl/bulls_cows_pkg.sv - shared game-state type and width helpers for the arena
package bulls_cows_pkg;

    typedef enum logic [1:0] {
        SETUP = 2'd0,
        PLAY  = 2'd1,
        WIN   = 2'd2,
        DRAW  = 2'd3
    } state_t;

    // Total width of a code made of `digits` digits of `digit_w` bits each.
    function automatic int code_w(input int digits, input int digit_w);
        return digits * digit_w;
    endfunction

    // Bits needed to hold a count from 0 up to and including n.
    function automatic int count_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Bits needed to index a player; never narrower than one bit.
    function automatic int player_w(input int players);
        return (players > 2) ? $clog2(players) : 1;
    endfunction

endpackage

// File: rtl/bulls_cows_scorer.sv
// rtl/bulls_cows_scorer.sv - combinational bulls/cows scorer and digit-distinctness check
module bulls_cows_scorer
    import bulls_cows_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
) (
    input  logic [code_w(DIGITS, DIGIT_W)-1:0] code_a,
    input  logic [code_w(DIGITS, DIGIT_W)-1:0] code_b,
    output logic [count_w(DIGITS)-1:0]         bulls,
    output logic [count_w(DIGITS)-1:0]         cows,
    output logic                               a_distinct
);

    localparam int CW = count_w(DIGITS);

    // Compare every digit of a against every digit of b; same-position hits are bulls,
    // cross-position hits are cows, and any repeated digit within a clears a_distinct.
    always_comb begin
        bulls      = '0;
        cows       = '0;
        a_distinct = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            for (int j = 0; j < DIGITS; j++) begin
                if (code_a[k*DIGIT_W +: DIGIT_W] == code_b[j*DIGIT_W +: DIGIT_W]) begin
                    if (k == j) begin
                        bulls = bulls + CW'(1);
                    end else begin
                        cows = cows + CW'(1);
                    end
                end
                if ((j > k) && (code_a[k*DIGIT_W +: DIGIT_W] == code_a[j*DIGIT_W +: DIGIT_W])) begin
                    a_distinct = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/bulls_cows_arena.sv
// rtl/bulls_cows_arena.sv - multi-player Bulls & Cows game core (setup, round-robin play, win/draw)
module bulls_cows_arena
    import bulls_cows_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DIGIT_W    = 4,
    parameter int PLAYERS    = 2,
    parameter int MAX_ROUNDS = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [code_w(DIGITS, DIGIT_W)-1:0] guess,
    input  logic                               confirm,
    output state_t                             state,
    output logic [player_w(PLAYERS)-1:0]       player,
    output logic [count_w(DIGITS)-1:0]         bulls,
    output logic [count_w(DIGITS)-1:0]         cows,
    output logic                               result_valid,
    output logic                               error,
    output logic [player_w(PLAYERS)-1:0]       winner,
    output logic [count_w(MAX_ROUNDS)-1:0]     round
);

    localparam int CODE_W = code_w(DIGITS, DIGIT_W);
    localparam int PW     = player_w(PLAYERS);
    localparam int CW     = count_w(DIGITS);
    localparam int RW     = count_w(MAX_ROUNDS);

    logic              confirm_q;
    logic [CODE_W-1:0] secret [PLAYERS];

    logic              commit;
    logic              last_player;
    logic [PW-1:0]     target;
    logic [CODE_W-1:0] target_code;
    logic [CW-1:0]     sc_bulls;
    logic [CW-1:0]     sc_cows;
    logic              sc_distinct;
    logic [RW-1:0]     round_inc;

    state_t            state_nxt;
    logic [PW-1:0]     player_nxt;
    logic [PW-1:0]     winner_nxt;
    logic [RW-1:0]     round_nxt;
    logic [CW-1:0]     bulls_nxt;
    logic [CW-1:0]     cows_nxt;
    logic              rv_nxt;
    logic              err_nxt;
    logic              secret_we;

    assign commit      = confirm & ~confirm_q;
    assign last_player = (player == PW'(PLAYERS - 1));
    assign target      = last_player ? '0 : player + PW'(1);
    assign round_inc   = round + RW'(1);
    // Only play scoring needs a real second operand; setup just uses a_distinct.
    assign target_code = (state == PLAY) ? secret[target] : '0;

    bulls_cows_scorer #(
        .DIGITS  (DIGITS),
        .DIGIT_W (DIGIT_W)
    ) u_scorer (
        .code_a     (guess),
        .code_b     (target_code),
        .bulls      (sc_bulls),
        .cows       (sc_cows),
        .a_distinct (sc_distinct)
    );

    // Register game state, counters, secrets and the one-cycle result/error pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            confirm_q    <= 1'b0;
            state        <= SETUP;
            player       <= '0;
            winner       <= '0;
            round        <= '0;
            bulls        <= '0;
            cows         <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            for (int i = 0; i < PLAYERS; i++) begin
                secret[i] <= '0;
            end
        end else begin
            confirm_q    <= confirm;
            state        <= state_nxt;
            player       <= player_nxt;
            winner       <= winner_nxt;
            round        <= round_nxt;
            bulls        <= bulls_nxt;
            cows         <= cows_nxt;
            result_valid <= rv_nxt;
            error        <= err_nxt;
            if (secret_we) begin
                secret[player] <= guess;
            end
        end
    end

    // Decide what a commit does in the current phase; terminal phases ignore commits.
    always_comb begin
        state_nxt  = state;
        player_nxt = player;
        winner_nxt = winner;
        round_nxt  = round;
        bulls_nxt  = bulls;
        cows_nxt   = cows;
        rv_nxt     = 1'b0;
        err_nxt    = 1'b0;
        secret_we  = 1'b0;
        if (commit && ((state == SETUP) || (state == PLAY))) begin
            if (!sc_distinct) begin
                err_nxt = 1'b1;
            end else if (state == SETUP) begin
                secret_we  = 1'b1;
                player_nxt = target;
                if (last_player) begin
                    state_nxt = PLAY;
                end
            end else begin
                bulls_nxt = sc_bulls;
                cows_nxt  = sc_cows;
                rv_nxt    = 1'b1;
                if (sc_bulls == CW'(DIGITS)) begin
                    state_nxt  = WIN;
                    winner_nxt = player;
                end else begin
                    player_nxt = target;
                    if (last_player) begin
                        round_nxt = round_inc;
                        if (round_inc == RW'(MAX_ROUNDS)) begin
                            state_nxt = DRAW;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bulls_cows_arena.sv
// tb/tb_bulls_cows_arena.sv - scoreboard bench for bulls_cows_arena (default and single-round instances)
module tb_bulls_cows_arena;
    import bulls_cows_pkg::*;

    typedef struct {
        int rv;
        int err;
        int bulls;
        int cows;
        int st;
        int pl;
        int rnd;
        int win;
    } exp_t;

    typedef struct {
        exp_t a;
        exp_t b;
    } entry_t;

    logic        clock;
    logic        reset;
    logic [15:0] guess;
    logic        confirm;

    state_t      state_a, state_b;
    logic [0:0]  player_a, player_b, winner_a, winner_b;
    logic [2:0]  bulls_a, bulls_b, cows_a, cows_b;
    logic        rv_a, rv_b, err_a, err_b;
    logic [3:0]  round_a;
    logic [0:0]  round_b;

    bulls_cows_arena dut_a (
        .clock(clock), .reset(reset), .guess(guess), .confirm(confirm),
        .state(state_a), .player(player_a), .bulls(bulls_a), .cows(cows_a),
        .result_valid(rv_a), .error(err_a), .winner(winner_a), .round(round_a)
    );

    bulls_cows_arena #(.MAX_ROUNDS(1)) dut_b (
        .clock(clock), .reset(reset), .guess(guess), .confirm(confirm),
        .state(state_b), .player(player_b), .bulls(bulls_b), .cows(cows_b),
        .result_valid(rv_b), .error(err_b), .winner(winner_b), .round(round_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    entry_t      sb_q[$];
    logic        cprev, tb_commit;
    bit          run = 0;

    int          m_state [2];
    int          m_player[2];
    int          m_round [2];
    int          m_winner[2];
    int          m_bulls [2];
    int          m_cows  [2];
    logic [15:0] m_secret[2][2];
    int          m_max   [2] = '{8, 1};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int nib(input logic [15:0] c, input int k);
        return int'(c[k*4 +: 4]);
    endfunction

    function automatic bit distinct(input logic [15:0] c);
        bit seen [16];
        for (int i = 0; i < 16; i++) seen[i] = 0;
        for (int k = 0; k < 4; k++) begin
            if (seen[nib(c, k)]) return 0;
            seen[nib(c, k)] = 1;
        end
        return 1;
    endfunction

    function automatic int count_bulls(input logic [15:0] g, input logic [15:0] s);
        int n = 0;
        for (int k = 0; k < 4; k++) if (nib(g, k) == nib(s, k)) n++;
        return n;
    endfunction

    function automatic int count_common(input logic [15:0] g, input logic [15:0] s);
        int n = 0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                if (nib(g, k) == nib(s, j)) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_player[i] = 0; m_round[i] = 0; m_winner[i] = 0;
            m_bulls[i] = 0; m_cows[i] = 0;
            m_secret[i][0] = '0; m_secret[i][1] = '0;
        end
    endtask

    task automatic model_commit(input int i, input logic [15:0] g, output exp_t e);
        int t, b;
        e.rv = 0;
        e.err = 0;
        if (m_state[i] == 0 || m_state[i] == 1) begin
            t = (m_player[i] + 1) % 2;
            if (!distinct(g)) begin
                e.err = 1;
            end else if (m_state[i] == 0) begin
                m_secret[i][m_player[i]] = g;
                m_player[i] = t;
                if (t == 0) m_state[i] = 1;
            end else begin
                b = count_bulls(g, m_secret[i][t]);
                m_bulls[i] = b;
                m_cows[i]  = count_common(g, m_secret[i][t]) - b;
                e.rv = 1;
                if (b == 4) begin
                    m_state[i]  = 2;
                    m_winner[i] = m_player[i];
                end else begin
                    m_player[i] = t;
                    if (t == 0) begin
                        m_round[i]++;
                        if (m_round[i] == m_max[i]) m_state[i] = 3;
                    end
                end
            end
        end
        e.bulls = m_bulls[i];
        e.cows  = m_cows[i];
        e.st    = m_state[i];
        e.pl    = m_player[i];
        e.rnd   = m_round[i];
        e.win   = m_winner[i];
    endtask

    task automatic check_inst(input string n, input exp_t e, input int rv, input int err,
                              input int b, input int c, input int st, input int pl,
                              input int rnd, input int win);
        check({n, "_result_valid"}, rv, e.rv);
        check({n, "_error"}, err, e.err);
        check({n, "_bulls"}, b, e.bulls);
        check({n, "_cows"}, c, e.cows);
        check({n, "_state"}, st, e.st);
        check({n, "_player"}, pl, e.pl);
        check({n, "_round"}, rnd, e.rnd);
        check({n, "_winner"}, win, e.win);
    endtask

    task automatic check_reset_values(input string n);
        check({n, "_a_state"}, int'(state_a), int'(SETUP));
        check({n, "_a_player"}, int'(player_a), 0);
        check({n, "_a_bulls"}, int'(bulls_a), 0);
        check({n, "_a_cows"}, int'(cows_a), 0);
        check({n, "_a_rv"}, int'(rv_a), 0);
        check({n, "_a_err"}, int'(err_a), 0);
        check({n, "_a_winner"}, int'(winner_a), 0);
        check({n, "_a_round"}, int'(round_a), 0);
        check({n, "_b_state"}, int'(state_b), int'(SETUP));
        check({n, "_b_player"}, int'(player_b), 0);
        check({n, "_b_round"}, int'(round_b), 0);
    endtask

    // Track commits as the bench itself sees them, so the monitor knows when a result is due.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cprev     <= 1'b0;
            tb_commit <= 1'b0;
        end else begin
            tb_commit <= confirm & ~cprev;
            cprev     <= confirm;
        end
    end

    // Pop and compare one scoreboard entry per commit; otherwise no pulses may appear.
    always @(negedge clock) begin
        entry_t ent;
        if (run && !reset) begin
            if (tb_commit) begin
                if (sb_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    ent = sb_q.pop_front();
                    check_inst("a", ent.a, int'(rv_a), int'(err_a), int'(bulls_a), int'(cows_a),
                               int'(state_a), int'(player_a), int'(round_a), int'(winner_a));
                    check_inst("b", ent.b, int'(rv_b), int'(err_b), int'(bulls_b), int'(cows_b),
                               int'(state_b), int'(player_b), int'(round_b), int'(winner_b));
                end
            end else begin
                check("a_idle_pulse", int'(rv_a | err_a), 0);
                check("b_idle_pulse", int'(rv_b | err_b), 0);
            end
        end
    end

    task automatic commit(input logic [15:0] g, input int hold);
        exp_t   ea, eb;
        entry_t ent;
        @(posedge clock); #2;
        guess   = g;
        confirm = 1'b1;
        model_commit(0, g, ea);
        model_commit(1, g, eb);
        ent.a = ea;
        ent.b = eb;
        sb_q.push_back(ent);
        repeat (hold) @(posedge clock);
        #2 confirm = 1'b0;
        @(posedge clock);
    endtask

    task automatic do_reset();
        @(posedge clock); #3;
        reset = 1'b1;
        #1 check_reset_values("reset");
        model_reset();
        @(posedge clock); #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] r;
        reset   = 1'b1;
        guess   = '0;
        confirm = 1'b0;
        model_reset();
        #1 check_reset_values("por");
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        run = 1;

        commit(16'h1123, 1);
        commit(16'h0F35, 1);
        commit(16'h1234, 1);
        commit(16'h1243, 1);
        commit(16'h0F35, 1);
        commit(16'h0F35, 1);
        commit(16'h1234, 1);

        do_reset();
        commit(16'h0123, 1);
        commit(16'h4567, 1);
        commit(16'h89AB, 5);
        commit(16'hCDEF, 1);
        commit(16'h1111, 1);
        commit(16'h7654, 1);
        commit(16'h3210, 1);
        for (int i = 0; i < 4; i++) begin
            r = 16'($urandom());
            commit(r, 1 + (i % 2));
        end

        do_reset();
        commit(16'h0123, 1);
        commit(16'h0123, 1);
        repeat (3) @(posedge clock);
        #2 check("scoreboard_drained", sb_q.size(), 0);
        run = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
